// File: rtl/dsconv_block_pointwise_output_writer_pkg.sv
// Shared definitions for the dsconv block output writers.
//  - Pixel format: 18-bit signed, 9 fractional bits.
//  - Saturation bounds for the 18-bit pixel format.
//  - FSM state encodings shared by the writer controllers.
//  - sext19: sign-extends an 18-bit pixel to the 19-bit adder width.
package dsconv_block_pointwise_output_writer_pkg;

    localparam int PIX_W     = 18;
    localparam int FRAC_BITS = 9;

    localparam logic signed [PIX_W-1:0] PIX_MAX = 18'sh1FFFF;  //  131071
    localparam logic signed [PIX_W-1:0] PIX_MIN = 18'sh20000;  // -131072

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // One guard bit is enough: the sum of two 18-bit values always fits in 19 bits.
    function automatic logic signed [PIX_W:0] sext19(input logic signed [PIX_W-1:0] v);
        return {v[PIX_W-1], v};
    endfunction

endpackage

// File: rtl/dsconv_block_pointwise_output_writer_act_sat.sv
// dsconv_block_act_sat: combinational activation + saturation.
// Takes a 19-bit signed sum (pixel + bias) and produces an 18-bit pixel.
//  sum_in   in   19  signed sum, 9 frac bits
//  act_out  out  18  ReLU'd (when RELU_EN) and saturated pixel
// Also used by the depthwise writer.
module dsconv_block_act_sat
    import dsconv_block_pointwise_output_writer_pkg::*;
#(
    parameter int RELU_EN = 1
) (
    input  logic signed [PIX_W:0]   sum_in,
    output logic signed [PIX_W-1:0] act_out
);

    always_comb begin
        act_out = sum_in[PIX_W-1:0];
        if ((RELU_EN != 0) && sum_in[PIX_W]) begin
            act_out = '0;
        end else if (sum_in > sext19(PIX_MAX)) begin
            act_out = PIX_MAX;
        end else if (sum_in < sext19(PIX_MIN)) begin
            act_out = PIX_MIN;
        end
    end

endmodule

// File: rtl/dsconv_block_pointwise_output_writer.sv
// dsconv_block_pointwise_output_writer
// Receives pointwise sums one output channel per cycle, adds the per-channel
// bias, applies ReLU/saturation and writes the result to the output feature
// memory at addr = pix*C_OUT + ch. Pulses done once a full frame is written.
// Ports:
//  clk, rst                 clock; synchronous active-high reset
//  frame_start              arms a new frame (honoured in IDLE only)
//  in_valid, pixel_in       one qualified 18-bit signed sum per cycle
//  bias_we/addr/din         bias register-file write port (any state)
//  mem_we/addr/din          registered feature-memory write port
//  busy                     high in RUN and FLUSH
//  done                     single-cycle pulse at frame end
//  err                      sticky: in_valid seen outside RUN
// Valid semantics: in_valid qualifies pixel_in for exactly that cycle; there
// is no ready/backpressure, so every value accepted in RUN produces a write
// exactly three cycles later and idle input cycles produce mem_we=0.
module dsconv_block_pointwise_output_writer
    import dsconv_block_pointwise_output_writer_pkg::*;
#(
    parameter int C_OUT   = 32,
    parameter int H       = 8,
    parameter int W       = 8,
    parameter int ADDR_W  = 11,
    parameter int RELU_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         pixel_in,
    input  logic                     bias_we,
    input  logic [$clog2(C_OUT)-1:0] bias_addr,
    input  logic [PIX_W-1:0]         bias_din,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [PIX_W-1:0]         mem_din,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int CH_W   = $clog2(C_OUT);
    localparam int PIXC_W = ADDR_W - CH_W;   // pixel counter fills the upper address bits
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(C_OUT - 1);
    localparam logic [PIXC_W-1:0] PIX_LAST = PIXC_W'(H * W - 1);

    // Control state
    logic [1:0]        state_q, state_d;
    logic [1:0]        flush_cnt_q, flush_cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PIXC_W-1:0] pix_q, pix_d;
    logic              err_q, err_d;

    // Bias register file (not reset)
    logic [PIX_W-1:0]  bias_q [C_OUT];
    logic [PIX_W-1:0]  bias_d [C_OUT];

    // Pipeline
    logic                     s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0]        s1_addr_q, s1_addr_d;
    logic signed [PIX_W:0]    s1_sum_q, s1_sum_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [ADDR_W-1:0]        s2_addr_q, s2_addr_d;
    logic [PIX_W-1:0]         s2_act_q, s2_act_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic [PIX_W-1:0]         mem_din_q, mem_din_d;

    logic                     take;
    logic signed [PIX_W-1:0]  act;

    assign take = in_valid && (state_q == ST_RUN);

    // ---------------- controller ----------------
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        ch_d        = ch_q;
        pix_d       = pix_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_RUN;
                    ch_d    = '0;
                    pix_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    ch_d = ch_q + 1'b1;   // C_OUT is a power of 2: wraps naturally
                    if (ch_q == CH_LAST) begin
                        pix_d = pix_q + 1'b1;
                        if (pix_q == PIX_LAST) begin
                            pix_d       = '0;
                            state_d     = ST_FLUSH;
                            flush_cnt_d = '0;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                // Held until the final value has been presented at the memory port,
                // so done lands one cycle after the last write.
                if (flush_cnt_q == 2'd2) begin
                    state_d = ST_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A stray value in the same cycle as frame_start still counts as an error.
        if (in_valid && (state_q != ST_RUN)) begin
            err_d = 1'b1;
        end
    end

    // ---------------- bias file ----------------
    // Reads in S1 use bias_q, so a same-cycle write to the same index is seen
    // only by later values.
    always_comb begin
        for (int i = 0; i < C_OUT; i++) begin
            bias_d[i] = bias_q[i];
        end
        if (bias_we) begin
            bias_d[bias_addr] = bias_din;
        end
    end

    // ---------------- datapath ----------------
    always_comb begin
        s1_valid_d = take;
        s1_addr_d  = {pix_q, ch_q};
        s1_sum_d   = sext19(pixel_in) + sext19(bias_q[ch_q]);
        s2_valid_d = s1_valid_q;
        s2_addr_d  = s1_addr_q;
        s2_act_d   = act;
        mem_we_d   = s2_valid_q;
        mem_addr_d = s2_addr_q;
        mem_din_d  = s2_act_q;
    end

    dsconv_block_act_sat #(
        .RELU_EN (RELU_EN)
    ) u_act_sat (
        .sum_in  (s1_sum_q),
        .act_out (act)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            ch_q        <= '0;
            pix_q       <= '0;
            err_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_sum_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_addr_q   <= '0;
            s2_act_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            ch_q        <= ch_d;
            pix_q       <= pix_d;
            err_q       <= err_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_sum_q    <= s1_sum_d;
            s2_valid_q  <= s2_valid_d;
            s2_addr_q   <= s2_addr_d;
            s2_act_q    <= s2_act_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < C_OUT; i++) begin
            bias_q[i] <= bias_d[i];
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_dsconv_block_pointwise_output_writer.sv
module tb_dsconv_block_pointwise_output_writer;

  localparam int C_OUT  = 4;
  localparam int H      = 2;
  localparam int W      = 2;
  localparam int ADDR_W = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        frame_start, in_valid, bias_we;
  logic [17:0] pixel_in, bias_din;
  logic [1:0]  bias_addr;
  logic        mem_we, busy, done, err;
  logic [3:0]  mem_addr;
  logic [17:0] mem_din;
  logic        nr_mem_we, nr_busy, nr_done, nr_err;
  logic [3:0]  nr_mem_addr;
  logic [17:0] nr_mem_din;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [17:0] din;
    logic [17:0] din_nr;
  } exp_t;
  exp_t exp_q[$];

  dsconv_block_pointwise_output_writer #(
    .C_OUT(C_OUT), .H(H), .W(W), .ADDR_W(ADDR_W), .RELU_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .pixel_in(pixel_in), .bias_we(bias_we), .bias_addr(bias_addr), .bias_din(bias_din),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .err(err)
  );

  // Same stimulus, ReLU disabled: exposes the negative saturation path.
  dsconv_block_pointwise_output_writer #(
    .C_OUT(C_OUT), .H(H), .W(W), .ADDR_W(ADDR_W), .RELU_EN(0)
  ) dut_nr (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .pixel_in(pixel_in), .bias_we(bias_we), .bias_addr(bias_addr), .bias_din(bias_din),
    .mem_we(nr_mem_we), .mem_addr(nr_mem_addr), .mem_din(nr_mem_din),
    .busy(nr_busy), .done(nr_done), .err(nr_err)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic exp_reset();
    exp_t z;
    z = '0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  // ---------------- driver ----------------
  // One clock cycle. Pushes the expected write for this cycle's input and
  // checks the memory port against the entry queued three cycles back.
  task automatic cyc(input logic v, input int px, input logic ew, input int ea,
                     input int ed, input int ed_nr);
    exp_t e, h;
    in_valid = v;
    pixel_in = 18'(px);
    e.we     = ew;
    e.addr   = 4'(ea);
    e.din    = 18'(ed);
    e.din_nr = 18'(ed_nr);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    bias_we     = 1'b0;
    h = exp_q.pop_front();
    chk("mem_we", 32'(mem_we), 32'(h.we));
    chk("nr_mem_we", 32'(nr_mem_we), 32'(h.we));
    if (h.we) begin
      chk("mem_addr", 32'(mem_addr), 32'(h.addr));
      chk("mem_din", 32'(mem_din), 32'(h.din));
      chk("nr_mem_addr", 32'(nr_mem_addr), 32'(h.addr));
      chk("nr_mem_din", 32'(nr_mem_din), 32'(h.din_nr));
    end
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic load_bias(input int idx, input int val);
    bias_we   = 1'b1;
    bias_addr = 2'(idx);
    bias_din  = 18'(val);
    idle();
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    idle();
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_after_start", 32'(err), 32'd0);
  endtask

  // Called right after the cycle carrying the last value of a frame.
  task automatic finish_frame();
    idle();
    chk("done_flush0", 32'(done), 32'd0);
    chk("busy_flush0", 32'(busy), 32'd1);
    idle();
    chk("done_lastwrite", 32'(done), 32'd0);
    chk("busy_lastwrite", 32'(busy), 32'd1);
    idle();
    chk("done_pulse", 32'(done), 32'd1);
    chk("nr_done_pulse", 32'(nr_done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    idle();
    chk("done_cleared", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t1_relu[4]  = '{768, 0, 256, 1280};
    int t1_nr[4]    = '{768, -256, 256, 1280};
    int t2_px[4]    = '{131000, -131072, -5, 100};
    int t2_relu[4]  = '{131071, 0, 0, 1124};
    int t2_nr[4]    = '{131071, -131072, -5, 1124};
    int t5_relu[4]  = '{1000, 0, 0, 1024};
    int t5_nr[4]    = '{1000, -1, 0, 1024};
    int t6_new[4]   = '{1010, 2058, 10, 1034};

    rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0; pixel_in = '0;
    bias_we = 1'b0; bias_addr = '0; bias_din = '0;
    exp_reset();

    // Reset state
    idle();
    idle();
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    idle();

    // 1: basic frame, bias [512,-512,0,1024], all inputs 256
    load_bias(0, 512);
    load_bias(1, -512);
    load_bias(2, 0);
    load_bias(3, 1024);
    start_frame();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 256, 1'b1, i, t1_relu[i % 4], t1_nr[i % 4]);
    end
    finish_frame();
    chk("t1_err", 32'(err), 32'd0);

    // 2 + 3: saturation vectors, fed with one-cycle gaps
    load_bias(0, 1000);
    load_bias(1, -1);
    start_frame();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, t2_px[i % 4], 1'b1, i, t2_relu[i % 4], t2_nr[i % 4]);
      if (i < 15) idle();
    end
    finish_frame();

    // 4: in_valid while IDLE
    cyc(1'b1, 7, 1'b0, 0, 0, 0);
    chk("t4_err_set", 32'(err), 32'd1);
    chk("t4_nr_err_set", 32'(nr_err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    idle();
    chk("t4_err_sticky", 32'(err), 32'd1);

    // 5: frame_start clears err; reset after 6 values
    start_frame();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 0, 1'b1, i, t5_relu[i % 4], t5_nr[i % 4]);
    end
    rst = 1'b1;
    exp_reset();
    idle();
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_nr_busy_rst", 32'(nr_busy), 32'd0);
    rst = 1'b0;
    idle();
    idle();

    // 6: bias write to index 1 alongside the ch=1 value; mid-frame frame_start ignored
    start_frame();
    for (int i = 0; i < 16; i++) begin
      if (i == 1) begin
        bias_we = 1'b1; bias_addr = 2'd1; bias_din = 18'd2048;
        cyc(1'b1, 10, 1'b1, i, 9, 9);
      end else begin
        if (i == 8) frame_start = 1'b1;
        cyc(1'b1, 10, 1'b1, i, t6_new[i % 4], t6_new[i % 4]);
      end
    end
    finish_frame();
    chk("t6_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
